eth_arp_frame_tx: RTL and testbench
===================================

// Module: eth_arp_frame_tx
// PURPOSE
//  Parametrised ARP frame generator for the MII/GMII transmit side of eth_mac_ss.
//  Builds one complete Ethernet/ARP frame from port fields: preamble, SFD, header, ARP body, pad and on-the-fly FCS.
//  Supports request and reply opcodes, a 4- or 8-bit data path, and an optional self-timed repeat mode.
//  Feeds the DDR output stage; txd/tx_en are registered.
// PARAMETERS
//  DATA_W       4      txd width; 4 = MII nibble (low nibble first), 8 = GMII byte; other values -> elaboration error
//  PRE_BYTES    7      preamble bytes of 8'h55 before SFD 8'hD5
//  IFG_BYTES    12     minimum idle bytes after FCS before next frame may start
//  AUTO_PERIOD  0      0 = start-driven only; N>0 = self-trigger every N clk cycles, counted from previous frame start
// PORTS
//  clk        in   1       transmit clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       request one frame; honoured only in IDLE
//  op_reply   in   1       0 = ARP request (oper 1), 1 = ARP reply (oper 2)
//  src_mac    in   48      sender MAC, byte [47:40] sent first
//  src_ip     in   32      sender IP
//  dst_mac    in   48      target MAC; used only when op_reply=1
//  dst_ip     in   32      target IP
//  busy       out  1       high from accepted start until end of IFG
//  done       out  1       one-cycle pulse on last IFG cycle
//  tx_en      out  1       frame valid; preamble through last FCS bit
//  tx_er      out  1       always 0; reserved
//  txd        out  DATA_W  transmit data
// BEHAVIOUR
//  Reset: state=IDLE; tx_en, tx_er, busy, done = 0; txd = 0; CRC = 32'hFFFFFFFF; period counter = 0.
//   Async assert mid-frame truncates the frame: tx_en drops without waiting for a clock edge.
//  Start: in IDLE, start=1 (or auto trigger) latches op_reply/src_mac/src_ip/dst_mac/dst_ip.
//   Fields may change afterwards without effect. Start while busy is ignored; nothing is queued.
//   The first preamble beat appears on txd/tx_en on the clk edge after acceptance (latency 1).
//  Beats per byte: BPB = 8/DATA_W. Byte counter idx steps once every BPB cycles.
//   DATA_W=4: bits [3:0] are sent, then [7:4].
//  FSM: IDLE -> PRE (PRE_BYTES) -> SFD (1) -> BODY (60 bytes) -> FCS (4) -> IFG (IFG_BYTES) -> IDLE.
//  BODY byte map, idx 0..59:
//   0-5    dst: FF..FF for a request, dst_mac for a reply
//   6-11   src_mac
//   12-13  08 06
//   14-15  00 01
//   16-17  08 00
//   18     06
//   19     04
//   20-21  00 01 or 00 02
//   22-27  src_mac
//   28-31  src_ip
//   32-37  target MAC: 00..00 for a request, dst_mac for a reply
//   38-41  dst_ip
//   42-59  00 (pad)
//  CRC-32: reflected poly 32'hEDB88320, init FFFFFFFF.
//   Updated once per BODY byte (bytes 0..59 only; not preamble/SFD).
//   FCS = ~CRC, sent LSB byte first; within each byte, low nibble first when DATA_W=4.
//  Auto mode (AUTO_PERIOD>0): the period counter reloads on every frame start.
//   On expiry in IDLE, a frame starts. On expiry while busy, one pending flag is set and the frame starts on return to IDLE.
//   A simultaneous start and expiry produce one frame and clear the pending flag.
//  done is asserted together with the final IFG cycle; busy falls on the next edge.
//   start is accepted on the cycle after busy falls.
//  Frame length is fixed at 64 bytes + 8 bytes preamble/SFD. Counters must not wrap inside a frame.
// STRUCTURE
//  eth_pkg: ETH_TYPE_ARP 16'h0806, ARP_HTYPE 16'h0001, ARP_PTYPE 16'h0800, HLEN 8'h06, PLEN 8'h04,
//   PRE_BYTE 8'h55, SFD_BYTE 8'hD5, CRC_POLY 32'hEDB88320, CRC_RESIDUE 32'hC704DD7B, FSM state localparams.
//  Sub-module eth_crc32_byte: combinational next-CRC for one byte; reused by the future RX checker.
// TESTING
//  1 DATA_W=8, request, src_mac=AC162DBB53A1, src_ip=C0A8000B, dst_ip=C0A80D45
//    -> 72 tx_en cycles; bytes 0-5 = FF; byte 20-21 = 00 01; CRC over body+FCS gives residue C704DD7B.
//  2 DATA_W=4, same fields -> 144 tx_en beats; first beats 5,5,...,5,D; FCS matches the bench model nibble-wise.
//  3 Reply, dst_mac=001122334455 -> bytes 0-5 and 32-37 = 00 11 22 33 44 55; oper = 00 02.
//  4 start re-pulsed mid-frame and fields changed -> frame unaltered, no second frame.
//    A start one cycle after done -> accepted; gap >= IFG_BYTES*BPB cycles.
//  5 AUTO_PERIOD=100, DATA_W=8 (frame+IFG = 84 cycles) -> frame starts spaced exactly 100 cycles.
//    AUTO_PERIOD=50 -> back-to-back frames at the IFG minimum via the pending flag.
//  6 rst_n low at BODY idx 30 -> tx_en=0 asynchronously, busy=0.
//    After release, start -> full, correct frame with fresh CRC.

Source files
------------

// File: rtl/eth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_pkg                                                      |
// | Description : Shared Ethernet/ARP constants, FSM states and the ARP body   |
// |               byte map used by the frame generator.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ARP_HTYPE    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE    = 16'h0800;
    localparam logic [7:0]  HLEN         = 8'h06;
    localparam logic [7:0]  PLEN         = 8'h04;
    localparam logic [7:0]  PRE_BYTE     = 8'h55;
    localparam logic [7:0]  SFD_BYTE     = 8'hD5;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

    localparam int BODY_BYTES = 60;
    localparam int FCS_BYTES  = 4;

    localparam int         ST_W    = 3;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_BODY = 3'd3;
    localparam logic [2:0] ST_FCS  = 3'd4;
    localparam logic [2:0] ST_IFG  = 3'd5;

    // Byte idx (0..59) of the Ethernet header + ARP payload + pad.
    function automatic logic [7:0] arp_body_byte(
        input logic [5:0]  idx,
        input logic        op_reply,
        input logic [47:0] src_mac,
        input logic [31:0] src_ip,
        input logic [47:0] dst_mac,
        input logic [31:0] dst_ip
    );
        logic [7:0] b;
        int         i;
        i = int'(idx);
        b = 8'h00;
        if (i < 6) begin
            b = op_reply ? dst_mac[8*(5-i) +: 8] : 8'hFF;
        end else if (i < 12) begin
            b = src_mac[8*(11-i) +: 8];
        end else if (i < 22) begin
            case (i)
                12:      b = ETH_TYPE_ARP[15:8];
                13:      b = ETH_TYPE_ARP[7:0];
                14:      b = ARP_HTYPE[15:8];
                15:      b = ARP_HTYPE[7:0];
                16:      b = ARP_PTYPE[15:8];
                17:      b = ARP_PTYPE[7:0];
                18:      b = HLEN;
                19:      b = PLEN;
                21:      b = op_reply ? 8'h02 : 8'h01;
                default: b = 8'h00;
            endcase
        end else if (i < 28) begin
            b = src_mac[8*(27-i) +: 8];
        end else if (i < 32) begin
            b = src_ip[8*(31-i) +: 8];
        end else if (i < 38) begin
            b = op_reply ? dst_mac[8*(37-i) +: 8] : 8'h00;
        end else if (i < 42) begin
            b = dst_ip[8*(41-i) +: 8];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_crc32_byte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_crc32_byte                                               |
// | Description : Combinational reflected CRC-32 advance by one byte.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = crc_in ^ {24'h000000, data};
        for (int b = 0; b < 8; b++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC_POLY) : (w_crc >> 1);
        end
        crc_out = w_crc;
    end

endmodule
`default_nettype wire

// File: rtl/eth_arp_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_arp_frame_tx                                             |
// | Description : ARP request/reply frame generator for the MII/GMII TX path,  |
// |               with on-the-fly FCS and optional self-timed repeat.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eth_arp_frame_tx
    import eth_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int PRE_BYTES   = 7,
    parameter int IFG_BYTES   = 12,
    parameter int AUTO_PERIOD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_reply,
    input  logic [47:0]       src_mac,
    input  logic [31:0]       src_ip,
    input  logic [47:0]       dst_mac,
    input  logic [31:0]       dst_ip,
    output logic              busy,
    output logic              done,
    output logic              tx_en,
    output logic              tx_er,
    output logic [DATA_W-1:0] txd
);

    localparam int          c_BPB       = 8 / DATA_W;
    localparam logic [0:0]  c_LAST_BEAT = 1'(c_BPB - 1);
    localparam logic [15:0] c_PRE_LAST  = 16'(PRE_BYTES - 1);
    localparam logic [15:0] c_BODY_LAST = 16'(BODY_BYTES - 1);
    localparam logic [15:0] c_FCS_LAST  = 16'(FCS_BYTES - 1);
    localparam logic [15:0] c_IFG_LAST  = 16'(IFG_BYTES - 1);

    if ((DATA_W != 4) && (DATA_W != 8)) begin : g_bad_data_w
        $error("eth_arp_frame_tx: DATA_W must be 4 or 8");
    end
    if ((PRE_BYTES < 1) || (IFG_BYTES < 1)) begin : g_bad_len
        $error("eth_arp_frame_tx: PRE_BYTES and IFG_BYTES must be at least 1");
    end

    logic [ST_W-1:0]   r_state;
    logic [15:0]       r_idx;
    logic [0:0]        r_beat;
    logic [31:0]       r_crc;
    logic              r_op;
    logic [47:0]       r_src_mac;
    logic [31:0]       r_src_ip;
    logic [47:0]       r_dst_mac;
    logic [31:0]       r_dst_ip;
    logic              r_busy;
    logic              r_done;
    logic              r_tx_en;
    logic [DATA_W-1:0] r_txd;

    logic              w_expire;
    logic              w_pending;
    logic              w_accept;
    logic [ST_W-1:0]   w_nxt_state;
    logic [15:0]       w_nxt_idx;
    logic [0:0]        w_nxt_beat;
    logic [7:0]        w_body_byte;
    logic [31:0]       w_fcs;
    logic [7:0]        w_nxt_byte;
    logic              w_nxt_en;
    logic [DATA_W-1:0] w_nxt_txd;
    logic [31:0]       w_crc_nxt;

    assign w_accept = (r_state == ST_IDLE) && (start || w_expire || w_pending);

    // Period counter restarts at every frame start; an expiry during a frame
    // is remembered so the next frame leaves as soon as IDLE is reached.
    if (AUTO_PERIOD > 0) begin : g_auto
        localparam int c_PER_W = ($clog2(AUTO_PERIOD) > 0) ? $clog2(AUTO_PERIOD) : 1;
        localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(AUTO_PERIOD - 1);

        logic [c_PER_W-1:0] r_period;
        logic               r_pending;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_period  <= '0;
                r_pending <= 1'b0;
            end else begin
                if (w_accept || w_expire) begin
                    r_period <= '0;
                end else begin
                    r_period <= r_period + 1'b1;
                end
                if (w_accept) begin
                    r_pending <= 1'b0;
                end else if (w_expire) begin
                    r_pending <= 1'b1;
                end
            end
        end

        assign w_expire  = (r_period == c_PER_LAST);
        assign w_pending = r_pending;
    end else begin : g_no_auto
        assign w_expire  = 1'b0;
        assign w_pending = 1'b0;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_beat  = r_beat;
        if (r_state == ST_IDLE) begin
            if (w_accept) begin
                w_nxt_state = ST_PRE;
                w_nxt_idx   = '0;
                w_nxt_beat  = '0;
            end
        end else if (r_beat != c_LAST_BEAT) begin
            w_nxt_beat = r_beat + 1'b1;
        end else begin
            w_nxt_beat = '0;
            w_nxt_idx  = r_idx + 1'b1;
            case (r_state)
                ST_PRE: begin
                    if (r_idx == c_PRE_LAST) begin
                        w_nxt_state = ST_SFD;
                        w_nxt_idx   = '0;
                    end
                end
                ST_SFD: begin
                    w_nxt_state = ST_BODY;
                    w_nxt_idx   = '0;
                end
                ST_BODY: begin
                    if (r_idx == c_BODY_LAST) begin
                        w_nxt_state = ST_FCS;
                        w_nxt_idx   = '0;
                    end
                end
                ST_FCS: begin
                    if (r_idx == c_FCS_LAST) begin
                        w_nxt_state = ST_IFG;
                        w_nxt_idx   = '0;
                    end
                end
                ST_IFG: begin
                    if (r_idx == c_IFG_LAST) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_idx   = '0;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_idx   = '0;
                end
            endcase
        end
    end

    assign w_body_byte = arp_body_byte(w_nxt_idx[5:0], r_op, r_src_mac, r_src_ip,
                                       r_dst_mac, r_dst_ip);
    assign w_fcs       = ~r_crc;

    // The CRC absorbs each body byte as its first beat goes out, so the
    // register already holds the final value when the FCS starts.
    eth_crc32_byte u_crc (
        .crc_in  (r_crc),
        .data    (w_body_byte),
        .crc_out (w_crc_nxt)
    );

    always_comb begin
        w_nxt_byte = 8'h00;
        case (w_nxt_state)
            ST_PRE:  w_nxt_byte = PRE_BYTE;
            ST_SFD:  w_nxt_byte = SFD_BYTE;
            ST_BODY: w_nxt_byte = w_body_byte;
            ST_FCS:  w_nxt_byte = w_fcs[8*w_nxt_idx[1:0] +: 8];
            default: w_nxt_byte = 8'h00;
        endcase
    end

    assign w_nxt_en  = (w_nxt_state == ST_PRE) || (w_nxt_state == ST_SFD) ||
                       (w_nxt_state == ST_BODY) || (w_nxt_state == ST_FCS);
    assign w_nxt_txd = DATA_W'(w_nxt_byte >> (DATA_W * int'(w_nxt_beat)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_beat    <= '0;
            r_crc     <= CRC_INIT;
            r_op      <= 1'b0;
            r_src_mac <= '0;
            r_src_ip  <= '0;
            r_dst_mac <= '0;
            r_dst_ip  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tx_en   <= 1'b0;
            r_txd     <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_beat  <= w_nxt_beat;
            r_tx_en <= w_nxt_en;
            r_txd   <= w_nxt_en ? w_nxt_txd : '0;
            r_busy  <= (w_nxt_state != ST_IDLE);
            r_done  <= (w_nxt_state == ST_IFG) && (w_nxt_idx == c_IFG_LAST) &&
                       (w_nxt_beat == c_LAST_BEAT);
            if (w_accept) begin
                r_op      <= op_reply;
                r_src_mac <= src_mac;
                r_src_ip  <= src_ip;
                r_dst_mac <= dst_mac;
                r_dst_ip  <= dst_ip;
                r_crc     <= CRC_INIT;
            end else if ((w_nxt_state == ST_BODY) && (w_nxt_beat == '0)) begin
                r_crc <= w_crc_nxt;
            end
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign tx_en = r_tx_en;
    assign tx_er = 1'b0;
    assign txd   = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_eth_arp_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_eth_arp_frame_tx                                          |
// | Description : Self-checking bench: byte/nibble frames, reply, restart,     |
// |               auto-repeat spacing and async reset against a frame model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_eth_arp_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_a_n = 1'b0;
    logic        r_start8 = 1'b0;
    logic        r_start4 = 1'b0;
    logic        r_start_a = 1'b0;
    logic        r_op = 1'b0;
    logic [47:0] r_smac = '0;
    logic [31:0] r_sip = '0;
    logic [47:0] r_dmac = '0;
    logic [31:0] r_dip = '0;

    logic       w_busy8, w_done8, w_tx_en8, w_tx_er8;
    logic [7:0] w_txd8;
    logic       w_busy4, w_done4, w_tx_en4, w_tx_er4;
    logic [3:0] w_txd4;
    logic       w_busy_a1, w_done_a1, w_tx_en_a1, w_tx_er_a1;
    logic [7:0] w_txd_a1;
    logic       w_busy_a2, w_done_a2, w_tx_en_a2, w_tx_er_a2;
    logic [7:0] w_txd_a2;

    always #5 clk = ~clk;

    eth_arp_frame_tx #(.DATA_W(8), .PRE_BYTES(7), .IFG_BYTES(12), .AUTO_PERIOD(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(r_start8), .op_reply(r_op), .src_mac(r_smac),
        .src_ip(r_sip), .dst_mac(r_dmac), .dst_ip(r_dip), .busy(w_busy8), .done(w_done8),
        .tx_en(w_tx_en8), .tx_er(w_tx_er8), .txd(w_txd8));

    eth_arp_frame_tx #(.DATA_W(4), .PRE_BYTES(7), .IFG_BYTES(12), .AUTO_PERIOD(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(r_start4), .op_reply(r_op), .src_mac(r_smac),
        .src_ip(r_sip), .dst_mac(r_dmac), .dst_ip(r_dip), .busy(w_busy4), .done(w_done4),
        .tx_en(w_tx_en4), .tx_er(w_tx_er4), .txd(w_txd4));

    eth_arp_frame_tx #(.DATA_W(8), .PRE_BYTES(7), .IFG_BYTES(12), .AUTO_PERIOD(100)) u_auto100 (
        .clk(clk), .rst_n(rst_a_n), .start(r_start_a), .op_reply(r_op), .src_mac(r_smac),
        .src_ip(r_sip), .dst_mac(r_dmac), .dst_ip(r_dip), .busy(w_busy_a1), .done(w_done_a1),
        .tx_en(w_tx_en_a1), .tx_er(w_tx_er_a1), .txd(w_txd_a1));

    eth_arp_frame_tx #(.DATA_W(8), .PRE_BYTES(7), .IFG_BYTES(12), .AUTO_PERIOD(50)) u_auto50 (
        .clk(clk), .rst_n(rst_a_n), .start(r_start_a), .op_reply(r_op), .src_mac(r_smac),
        .src_ip(r_sip), .dst_mac(r_dmac), .dst_ip(r_dip), .busy(w_busy_a2), .done(w_done_a2),
        .tx_en(w_tx_en_a2), .tx_er(w_tx_er_a2), .txd(w_txd_a2));

    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    logic [7:0] q8[$];
    logic [3:0] q4[$];
    int         ra100[$];
    int         ra50[$];
    int         n_done8 = 0;
    int         n_done4 = 0;
    int         last8 = 0;
    int         gap8 = 0;
    logic       r_en8_d = 1'b0;
    logic       r_a1_d = 1'b0;
    logic       r_a2_d = 1'b0;
    logic [7:0] exp_frame [72];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (w_tx_en8) q8.push_back(w_txd8);
        if (w_tx_en4) q4.push_back(w_txd4);
        if (w_done8) n_done8 <= n_done8 + 1;
        if (w_done4) n_done4 <= n_done4 + 1;
        r_en8_d <= w_tx_en8;
        if (w_tx_en8) last8 <= cyc;
        if (w_tx_en8 && !r_en8_d) gap8 <= cyc - last8 - 1;
        r_a1_d <= w_tx_en_a1;
        r_a2_d <= w_tx_en_a2;
        if (w_tx_en_a1 && !r_a1_d) ra100.push_back(cyc);
        if (w_tx_en_a2 && !r_a2_d) ra50.push_back(cyc);
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Frame model: preamble, SFD, 60-byte header/ARP/pad image, FCS LSB first.
    task automatic build_expected(input logic op, input logic [47:0] sm, input logic [31:0] si,
                                  input logic [47:0] dm, input logic [31:0] di);
        logic [479:0] body;
        logic [31:0]  crc;
        body = {op ? dm : {48{1'b1}}, sm, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                op ? 16'h0002 : 16'h0001, sm, si, op ? dm : 48'h0, di, 144'h0};
        for (int i = 0; i < 7; i++) exp_frame[i] = 8'h55;
        exp_frame[7] = 8'hD5;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            exp_frame[8+i] = body[479-8*i -: 8];
            crc = crc_update(crc, exp_frame[8+i]);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) exp_frame[68+i] = crc[8*i +: 8];
    endtask

    task automatic check_frame(input int which, input int base, input int total, input string tag);
        logic [7:0]  got [72];
        logic [31:0] crc;
        int          beats;
        beats = (which == 8) ? (q8.size() - base) : (q4.size() - base);
        check_value({tag, "_len"}, beats, (which == 8) ? total : 2 * total);
        if (beats >= ((which == 8) ? 72 : 144)) begin
            for (int i = 0; i < 72; i++) begin
                got[i] = (which == 8) ? q8[base+i] : {q4[base+2*i+1], q4[base+2*i]};
                check_value($sformatf("%s_byte%0d", tag, i), got[i], exp_frame[i]);
            end
            crc = 32'hFFFFFFFF;
            for (int i = 8; i < 72; i++) crc = crc_update(crc, got[i]);
            // Residue is quoted in non-reflected bit order.
            check_value({tag, "_residue"}, bitrev32(crc), 32'hC704DD7B);
        end
    endtask

    task automatic wait_idle(input int which, input string tag);
        int n;
        n = 0;
        while (((which == 8) ? w_busy8 : w_busy4) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_idle"}, (n < 400), 1);
    endtask

    task automatic set_fields(input logic op, input logic [47:0] sm, input logic [31:0] si,
                              input logic [47:0] dm, input logic [31:0] di);
        r_op   = op;
        r_smac = sm;
        r_sip  = si;
        r_dmac = dm;
        r_dip  = di;
        build_expected(op, sm, si, dm, di);
    endtask

    task automatic pulse_start(input int which, input string tag);
        @(negedge clk);
        if (which == 8) r_start8 = 1'b1; else r_start4 = 1'b1;
        @(negedge clk);
        r_start8 = 1'b0;
        r_start4 = 1'b0;
        check_value({tag, "_lat_en"}, (which == 8) ? w_tx_en8 : w_tx_en4, 1);
        check_value({tag, "_lat_txd"}, (which == 8) ? w_txd8 : 8'(w_txd4),
                    (which == 8) ? 8'h55 : 8'h05);
        check_value({tag, "_tx_er"}, (which == 8) ? w_tx_er8 : w_tx_er4, 0);
    endtask

    task automatic run_frame(input int which, input logic op, input logic [47:0] sm,
                             input logic [31:0] si, input logic [47:0] dm, input logic [31:0] di,
                             input string tag);
        int base;
        int d0;
        set_fields(op, sm, si, dm, di);
        base = (which == 8) ? q8.size() : q4.size();
        d0   = (which == 8) ? n_done8 : n_done4;
        pulse_start(which, tag);
        wait_idle(which, tag);
        @(negedge clk);
        check_frame(which, base, 72, tag);
        check_value({tag, "_done"}, ((which == 8) ? n_done8 : n_done4) - d0, 1);
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        int base;
        int d0;
        int n;
        #1;
        check_value("rst_tx_en8", w_tx_en8, 0);
        check_value("rst_busy8", w_busy8, 0);
        check_value("rst_done8", w_done8, 0);
        check_value("rst_txd8", w_txd8, 0);
        check_value("rst_tx_er8", w_tx_er8, 0);
        check_value("rst_tx_en4", w_tx_en4, 0);
        check_value("rst_txd4", w_txd4, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_value("idle_busy8", w_busy8, 0);

        run_frame(8, 1'b0, 48'hAC162DBB53A1, 32'hC0A8000B, rnd48(), 32'hC0A80D45, "t1_req8");
        run_frame(4, 1'b0, 48'hAC162DBB53A1, 32'hC0A8000B, rnd48(), 32'hC0A80D45, "t2_req4");
        run_frame(8, 1'b1, 48'hAC162DBB53A1, 32'hC0A8000B, 48'h001122334455, 32'hC0A80D45, "t3_rep8");
        run_frame(4, 1'b1, rnd48(), $urandom, 48'h001122334455, $urandom, "t3_rep4");
        for (int k = 0; k < 3; k++) begin
            run_frame(8, 1'($urandom), rnd48(), $urandom, rnd48(), $urandom, $sformatf("rnd8_%0d", k));
            run_frame(4, 1'($urandom), rnd48(), $urandom, rnd48(), $urandom, $sformatf("rnd4_%0d", k));
        end

        // Restart attempt mid-frame with new fields must be ignored.
        set_fields(1'b1, rnd48(), $urandom, rnd48(), $urandom);
        base = q8.size();
        d0   = n_done8;
        pulse_start(8, "t4a");
        repeat (30) @(negedge clk);
        r_start8 = 1'b1;
        r_op = ~r_op; r_smac = rnd48(); r_sip = $urandom; r_dmac = rnd48(); r_dip = $urandom;
        @(negedge clk);
        r_start8 = 1'b0;
        wait_idle(8, "t4a");
        repeat (60) @(negedge clk);
        check_frame(8, base, 72, "t4a");
        check_value("t4a_done", n_done8 - d0, 1);

        // Start in the cycle after done: accepted, gap at least the IFG.
        set_fields(1'($urandom), rnd48(), $urandom, rnd48(), $urandom);
        base = q8.size();
        pulse_start(8, "t4b");
        n = 0;
        while (!w_done8 && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        check_value("t4b_done_seen", (n < 400), 1);
        @(negedge clk);
        r_start8 = 1'b1;
        @(negedge clk);
        r_start8 = 1'b0;
        check_value("t4b_accept", w_busy8, 1);
        wait_idle(8, "t4c");
        @(negedge clk);
        check_frame(8, base, 144, "t4b");
        check_frame(8, base + 72, 72, "t4c");
        check_value("t4c_gap_ok", (gap8 >= 12), 1);

        // Async reset in the middle of the body.
        set_fields(1'($urandom), rnd48(), $urandom, rnd48(), $urandom);
        base = q8.size();
        pulse_start(8, "t6");
        n = 0;
        while ((q8.size() - base < 39) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        check_value("t6_reach_idx30", (n < 400), 1);
        #2 rst_n = 1'b0;
        #1;
        check_value("t6_tx_en_async", w_tx_en8, 0);
        check_value("t6_busy_async", w_busy8, 0);
        check_value("t6_txd_async", w_txd8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(8, 1'($urandom), rnd48(), $urandom, rnd48(), $urandom, "t6_after");

        // Auto-repeat spacing.
        @(negedge clk);
        n = cyc;
        rst_a_n = 1'b1;
        repeat (480) @(negedge clk);
        check_value("auto100_count", (ra100.size() >= 4), 1);
        check_value("auto50_count", (ra50.size() >= 5), 1);
        if (ra100.size() >= 4) begin
            check_value("auto100_first", ra100[0] - n, 100);
            for (int i = 1; i < 4; i++)
                check_value($sformatf("auto100_gap%0d", i), ra100[i] - ra100[i-1], 100);
        end
        if (ra50.size() >= 5) begin
            check_value("auto50_first", ra50[0] - n, 50);
            for (int i = 1; i < 5; i++)
                check_value($sformatf("auto50_gap%0d", i), ra50[i] - ra50[i-1], 85);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
